ampm_prefetch_issue: RTL and testbench
======================================

# ampm_prefetch_issue

Prefetch issue scheduler for the AMPM prefetcher. It accepts per-zone prefetch candidate masks from pattern matching and buffers them in a small in-order zone queue. It issues one line-granular prefetch address per handshake, nearest-to-trigger first, and reports each issued line so the pattern table can move that line from P_INIT to P_PRFT. It sits between pattern matching and the L2 prefetch request port.

## Interface
- ZONEW, 26, zone tag width (address bits above line index)
- NLINE, 8, cache lines per zone; power of two, ≥2
- LINEW, $clog2(NLINE), line-index width
- OFFW, 6, byte-offset bits within a line
- NQ, 4, zone queue depth; power of two
- ADDRW, ZONEW+LINEW+OFFW, prefetch address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cand_vld  in  1  candidate valid
- cand_rdy  out  1  candidate ready
- cand_zone  in  ZONEW  candidate zone tag
- cand_mask  in  NLINE  lines to prefetch
- cand_trig  in  LINEW  triggering demand line offset
- flush  in  1  synchronous queue clear
- pf_vld  out  1  prefetch request valid
- pf_rdy  in  1  prefetch request ready
- pf_addr  out  ADDRW  {zone, line, OFFW'b0}
- upd_vld  out  1  pattern-table update pulse
- upd_zone  out  ZONEW  zone of issued line
- upd_line  out  LINEW  issued line index
- busy  out  1  any queue slot or the output register is valid

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Each queue slot holds valid, zone, trig, pend[NLINE] and issued[NLINE]. The queue is a circular FIFO with head, tail and count.
- Match: cand_zone equals the zone of a valid slot. At most one slot can match.
- cand_rdy = ~flush & (count<NQ | match). It is combinational on cand_zone.
- An accepted candidate is the cycle where cand_vld & cand_rdy:
  - cand_mask==0: dropped. No state change.
  - match: pend |= cand_mask & ~issued; trig is unchanged.
  - otherwise: allocate the tail slot with pend=cand_mask, issued=0, trig=cand_trig; tail++, count++.
- Output register holds pf_vld/pf_addr.
  - It loads when pf_vld==0 or pf_vld & pf_rdy, and the head slot is valid.
  - Selected line is the first set pend bit in priority order trig, trig+1, trig−1, trig+2, trig−2, … Offsets outside [0,NLINE−1] are skipped (no wrap).
  - On load, the selected bit is cleared in pend and set in issued.
  - If pend becomes 0, the head slot is freed: head++, count−−.
- A merge into the head slot in the same cycle as a load uses the pre-load issued value plus the selected bit. A just-selected line is never re-pended.
- A slot freed in cycle N is not allocatable until N+1. cand_rdy uses the current count.
- pf_addr is stable while pf_vld & ~pf_rdy.
- The cycle after each pf_vld & pf_rdy: upd_vld=1 with the zone/line of that request. Otherwise upd_vld=0.
- flush: the next state clears all slots, head, tail, count and pf_vld. A handshake completing in the flush cycle still produces its upd pulse.
- Reset values: pf_vld=0, pf_addr=0, upd_vld=0, upd_zone=0, upd_line=0, busy=0, all slots invalid. cand_rdy=1 after reset when flush=0.

## Timing
- Candidate accepted in cycle 0 into an empty block → pf_vld in cycle 2.
- Sustained throughput: one prefetch per cycle while pf_rdy=1 and the queue is non-empty. No bubble between slots.
- upd_vld lags its pf handshake by exactly 1 cycle.
- Reset assertion mid-operation clears everything immediately. No upd pulse is generated for an in-flight request.

## Test plan
- Single candidate, pf_rdy=1: zone=0x12345, mask=8'b1011_0001, trig=4. Required: pf_addr lines 4,5,7,0 in cycles 2–5. pf_addr = {0x12345, line, 6'b0}. upd pulses in cycles 3–6 with matching lines. busy=0 from cycle 6.
- Backpressure: same stimulus with pf_rdy=0 in cycles 2–6. Required: pf_addr stays line 4, no upd_vld. Line 5 follows the cycle after pf_rdy rises.
- Merge: zone A mask 8'b0000_0110, trig=1. After line 1 issues, send zone A mask 8'b0000_1010. Required: issue order 1,2,3 and line 1 is not re-issued.
- Full/match: pf_rdy=0, NQ=4. Accept zones A–D. Required: cand_rdy=0 for new zone E, cand_rdy=1 for zone C (merged), count stays 4.
- Zero mask and flush: cand_mask=0 is accepted but busy stays 0. Flush asserted mid-issue while pf_vld=1, pf_rdy=0. Required: pf_vld=0 next cycle, busy=0, cand_rdy=0 during the flush cycle.
- Reset mid-issue: rst_n low while pf_vld=1. Required: all outputs at reset values immediately. A new candidate after release gives pf_vld 2 cycles after its acceptance.

Source files
------------

// File: rtl/ampm_prefetch_issue.sv
// AMPM prefetch issue scheduler: buffers per-zone candidate masks in an in-order
// zone queue and issues one line address per handshake, nearest-to-trigger first.
module ampm_prefetch_issue #(
  parameter int ZONEW = 26,
  parameter int NLINE = 8,
  parameter int LINEW = $clog2(NLINE),
  parameter int OFFW  = 6,
  parameter int NQ    = 4,
  parameter int ADDRW = ZONEW + LINEW + OFFW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cand_vld,
  output logic             cand_rdy,
  input  logic [ZONEW-1:0] cand_zone,
  input  logic [NLINE-1:0] cand_mask,
  input  logic [LINEW-1:0] cand_trig,
  input  logic             flush,
  output logic             pf_vld,
  input  logic             pf_rdy,
  output logic [ADDRW-1:0] pf_addr,
  output logic             upd_vld,
  output logic [ZONEW-1:0] upd_zone,
  output logic [LINEW-1:0] upd_line,
  output logic             busy
);

  localparam int QW = $clog2(NQ);
  localparam int CW = QW + 1;

  logic [NQ-1:0]    slot_vld_q, slot_vld_d;
  logic [ZONEW-1:0] zone_q   [NQ];
  logic [ZONEW-1:0] zone_d   [NQ];
  logic [LINEW-1:0] trig_q   [NQ];
  logic [LINEW-1:0] trig_d   [NQ];
  logic [NLINE-1:0] pend_q   [NQ];
  logic [NLINE-1:0] pend_d   [NQ];
  logic [NLINE-1:0] issued_q [NQ];
  logic [NLINE-1:0] issued_d [NQ];

  logic [QW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic             pf_vld_q, pf_vld_d;
  logic [ADDRW-1:0] pf_addr_q, pf_addr_d;
  logic             upd_vld_q, upd_vld_d;
  logic [ZONEW-1:0] upd_zone_q, upd_zone_d;
  logic [LINEW-1:0] upd_line_q, upd_line_d;

  logic             match;
  logic [QW-1:0]    match_idx;
  logic             accept, alloc, merge;
  logic             load, pf_fire, head_free;
  logic [NLINE-1:0] head_pend;
  logic [LINEW-1:0] head_trig;
  logic [LINEW-1:0] sel_line;
  logic [NLINE-1:0] sel_bit;
  int               sel_rank, best_rank;

  // Zone lookup: allocation never creates a duplicate zone, so at most one hit.
  // NOTE: every always_comb output gets a default before any branch, so no latches are inferred.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = 0; i < NQ; i++) begin
      if (slot_vld_q[i] && (zone_q[i] == cand_zone)) begin
        match     = 1'b1;
        match_idx = QW'(i);
      end
    end
  end

  assign cand_rdy = ~flush & ((count_q < CW'(NQ)) | match);
  assign accept   = cand_vld & cand_rdy;
  assign alloc    = accept & (|cand_mask) & ~match;
  assign merge    = accept & (|cand_mask) & match;

  // Rank order around the trigger: t, t+1, t-1, t+2, t-2, ... with no wrap.
  always_comb begin
    head_pend = pend_q[head_q];
    head_trig = trig_q[head_q];
    best_rank = 2 * NLINE;
    sel_rank  = 0;
    sel_line  = '0;
    for (int l = 0; l < NLINE; l++) begin
      if (l > int'(head_trig)) sel_rank = 2 * (l - int'(head_trig)) - 1;
      else                     sel_rank = 2 * (int'(head_trig) - l);
      if (head_pend[l] && (sel_rank < best_rank)) begin
        best_rank = sel_rank;
        sel_line  = LINEW'(l);
      end
    end
  end

  assign sel_bit = NLINE'(1) << sel_line;
  assign pf_fire = pf_vld_q & pf_rdy;
  assign load    = slot_vld_q[head_q] & (~pf_vld_q | pf_rdy);

  always_comb begin
    slot_vld_d = slot_vld_q;
    zone_d     = zone_q;
    trig_d     = trig_q;
    pend_d     = pend_q;
    issued_d   = issued_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pf_vld_d   = pf_vld_q;
    pf_addr_d  = pf_addr_q;
    head_free  = 1'b0;

    if (load) begin
      pend_d[head_q]   = head_pend & ~sel_bit;
      issued_d[head_q] = issued_q[head_q] | sel_bit;
      pf_vld_d         = 1'b1;
      pf_addr_d        = {zone_q[head_q], sel_line, {OFFW{1'b0}}};
    end else if (pf_fire) begin
      pf_vld_d = 1'b0;
    end

    // issued_d already includes this cycle's selection, so it is never re-pended.
    if (merge) begin
      pend_d[match_idx] = pend_d[match_idx] | (cand_mask & ~issued_d[match_idx]);
    end

    if (alloc) begin
      slot_vld_d[tail_q] = 1'b1;
      zone_d[tail_q]     = cand_zone;
      trig_d[tail_q]     = cand_trig;
      pend_d[tail_q]     = cand_mask;
      issued_d[tail_q]   = '0;
      tail_d             = tail_q + QW'(1);
    end

    if (load && (pend_d[head_q] == '0)) begin
      head_free          = 1'b1;
      slot_vld_d[head_q] = 1'b0;
      head_d             = head_q + QW'(1);
    end

    count_d = count_q + CW'(alloc) - CW'(head_free);

    if (flush) begin
      slot_vld_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      pf_vld_d   = 1'b0;
    end
  end

  // The update pulse follows a handshake even when that cycle also flushes.
  always_comb begin
    upd_vld_d  = pf_fire;
    upd_zone_d = upd_zone_q;
    upd_line_d = upd_line_q;
    if (pf_fire) begin
      upd_zone_d = pf_addr_q[ADDRW-1 -: ZONEW];
      upd_line_d = pf_addr_q[OFFW +: LINEW];
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pf_vld_q   <= 1'b0;
      pf_addr_q  <= '0;
      upd_vld_q  <= 1'b0;
      upd_zone_q <= '0;
      upd_line_q <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pf_vld_q   <= pf_vld_d;
      pf_addr_q  <= pf_addr_d;
      upd_vld_q  <= upd_vld_d;
      upd_zone_q <= upd_zone_d;
      upd_line_q <= upd_line_d;
    end
  end

  // NOTE: slot payload arrays are not reset; slot_vld_q gates every use of their contents.
  always_ff @(posedge clk) begin
    zone_q   <= zone_d;
    trig_q   <= trig_d;
    pend_q   <= pend_d;
    issued_q <= issued_d;
  end

  assign pf_vld   = pf_vld_q;
  assign pf_addr  = pf_addr_q;
  assign upd_vld  = upd_vld_q;
  assign upd_zone = upd_zone_q;
  assign upd_line = upd_line_q;
  assign busy     = (|slot_vld_q) | pf_vld_q;

endmodule

// File: tb/tb_ampm_prefetch_issue.sv
// Directed bench for ampm_prefetch_issue: a vector table for the single-zone
// issue and backpressure runs, plus hand sequences for merge/full/flush/reset.
module tb_ampm_prefetch_issue;

  localparam int ZONEW = 26;
  localparam int NLINE = 8;
  localparam int LINEW = 3;
  localparam int OFFW  = 6;
  localparam int NQ    = 4;
  localparam int ADDRW = ZONEW + LINEW + OFFW;

  localparam logic [ZONEW-1:0] ZT = 26'h12345;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cand_vld;
  logic             cand_rdy;
  logic [ZONEW-1:0] cand_zone;
  logic [NLINE-1:0] cand_mask;
  logic [LINEW-1:0] cand_trig;
  logic             flush;
  logic             pf_vld;
  logic             pf_rdy;
  logic [ADDRW-1:0] pf_addr;
  logic             upd_vld;
  logic [ZONEW-1:0] upd_zone;
  logic [LINEW-1:0] upd_line;
  logic             busy;

  int errors = 0;
  int checks = 0;

  ampm_prefetch_issue #(
    .ZONEW(ZONEW), .NLINE(NLINE), .OFFW(OFFW), .NQ(NQ)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cand_vld(cand_vld), .cand_rdy(cand_rdy), .cand_zone(cand_zone),
    .cand_mask(cand_mask), .cand_trig(cand_trig), .flush(flush),
    .pf_vld(pf_vld), .pf_rdy(pf_rdy), .pf_addr(pf_addr),
    .upd_vld(upd_vld), .upd_zone(upd_zone), .upd_line(upd_line),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             cand_vld;
    logic [NLINE-1:0] mask;
    logic [LINEW-1:0] trig;
    logic             pf_rdy;
    logic             exp_cand_rdy;
    logic             exp_pf_vld;
    logic [LINEW-1:0] exp_pf_line;
    logic             exp_upd_vld;
    logic [LINEW-1:0] exp_upd_line;
    logic             exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [ADDRW-1:0] addr_of(input logic [ZONEW-1:0] z, input logic [LINEW-1:0] l);
    return {z, l, {OFFW{1'b0}}};
  endfunction

  function automatic vec_t mk(input logic cv, input logic [NLINE-1:0] m, input logic [LINEW-1:0] t,
                              input logic rdy, input logic crdy, input logic pv, input logic [LINEW-1:0] pl,
                              input logic uv, input logic [LINEW-1:0] ul, input logic bz);
    vec_t v;
    v.cand_vld = cv;   v.mask = m;          v.trig = t;        v.pf_rdy = rdy;
    v.exp_cand_rdy = crdy; v.exp_pf_vld = pv; v.exp_pf_line = pl;
    v.exp_upd_vld = uv; v.exp_upd_line = ul; v.exp_busy = bz;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [ZONEW-1:0] z, input logic [NLINE-1:0] m,
                       input logic [LINEW-1:0] t, input logic rdy, input logic fl);
    cand_vld = cv; cand_zone = z; cand_mask = m; cand_trig = t; pf_rdy = rdy; flush = fl;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    drive(v.cand_vld, ZT, v.mask, v.trig, v.pf_rdy, 1'b0);
    #1;
    check($sformatf("vec%0d cand_rdy", idx), 64'(cand_rdy), 64'(v.exp_cand_rdy));
    check($sformatf("vec%0d pf_vld", idx), 64'(pf_vld), 64'(v.exp_pf_vld));
    if (v.exp_pf_vld)
      check($sformatf("vec%0d pf_addr", idx), 64'(pf_addr), 64'(addr_of(ZT, v.exp_pf_line)));
    check($sformatf("vec%0d upd_vld", idx), 64'(upd_vld), 64'(v.exp_upd_vld));
    if (v.exp_upd_vld) begin
      check($sformatf("vec%0d upd_zone", idx), 64'(upd_zone), 64'(ZT));
      check($sformatf("vec%0d upd_line", idx), 64'(upd_line), 64'(v.exp_upd_line));
    end
    check($sformatf("vec%0d busy", idx), 64'(busy), 64'(v.exp_busy));
    tick();
  endtask

  initial begin
    logic [ZONEW-1:0] za;
    logic [ZONEW-1:0] zb;

    // Single candidate, pf_rdy=1: lines 4,5,7,0 in cycles 2..5, upd in 3..6.
    vecs.push_back(mk(1, 8'b1011_0001, 3'd4, 1,  1, 0, 3'd0, 0, 3'd0, 0));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 0, 3'd0, 0, 3'd0, 1));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 1, 3'd4, 0, 3'd0, 1));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 1, 3'd5, 1, 3'd4, 1));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 1, 3'd7, 1, 3'd5, 1));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 1, 3'd0, 1, 3'd7, 1));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 0, 3'd0, 1, 3'd0, 0));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 0, 3'd0, 0, 3'd0, 0));
    // Same candidate with pf_rdy=0 in cycles 2..6.
    vecs.push_back(mk(1, 8'b1011_0001, 3'd4, 1,  1, 0, 3'd0, 0, 3'd0, 0));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 0, 3'd0, 0, 3'd0, 1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 8'h00, 3'd0, 0,  1, 1, 3'd4, 0, 3'd0, 1));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 1, 3'd4, 0, 3'd0, 1));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 1, 3'd5, 1, 3'd4, 1));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 1, 3'd7, 1, 3'd5, 1));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 1, 3'd0, 1, 3'd7, 1));
    vecs.push_back(mk(0, 8'h00, 3'd0, 1,  1, 0, 3'd0, 1, 3'd0, 0));

    // Reset state.
    rst_n = 1'b0;
    drive(0, '0, '0, '0, 1'b0, 1'b0);
    #2;
    check("reset pf_vld", 64'(pf_vld), 64'd0);
    check("reset pf_addr", 64'(pf_addr), 64'd0);
    check("reset upd_vld", 64'(upd_vld), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset cand_rdy", 64'(cand_rdy), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Merge into the head slot in the same cycle line 2 is selected.
    za = 26'h0A;
    drive(1, za, 8'b0000_0110, 3'd1, 1, 0); #1;
    check("merge c0 cand_rdy", 64'(cand_rdy), 64'd1);
    tick();
    drive(0, '0, '0, '0, 1, 0); #1;
    check("merge c1 pf_vld", 64'(pf_vld), 64'd0);
    tick();
    drive(1, za, 8'b0000_1010, 3'd0, 1, 0); #1;
    check("merge c2 pf_vld", 64'(pf_vld), 64'd1);
    check("merge c2 pf_addr", 64'(pf_addr), 64'(addr_of(za, 3'd1)));
    check("merge c2 cand_rdy", 64'(cand_rdy), 64'd1);
    tick();
    drive(0, '0, '0, '0, 1, 0); #1;
    check("merge c3 pf_addr", 64'(pf_addr), 64'(addr_of(za, 3'd2)));
    check("merge c3 upd_line", 64'(upd_line), 64'd1);
    tick();
    #1;
    check("merge c4 pf_vld", 64'(pf_vld), 64'd1);
    check("merge c4 pf_addr", 64'(pf_addr), 64'(addr_of(za, 3'd3)));
    tick();
    #1;
    check("merge c5 pf_vld", 64'(pf_vld), 64'd0);
    check("merge c5 upd_line", 64'(upd_line), 64'd3);
    check("merge c5 busy", 64'(busy), 64'd0);
    tick();

    // Full queue with pf_rdy=0: new zone refused, resident zone merges.
    for (int i = 0; i < NQ; i++) begin
      drive(1, 26'h100 + ZONEW'(i), 8'b0000_0011, 3'd0, 0, 0); #1;
      check($sformatf("full alloc%0d cand_rdy", i), 64'(cand_rdy), 64'd1);
      tick();
    end
    drive(1, 26'h104, 8'b0000_0001, 3'd0, 0, 0); #1;
    check("full zoneE cand_rdy", 64'(cand_rdy), 64'd0);
    tick();
    drive(1, 26'h102, 8'b1000_0000, 3'd0, 0, 0); #1;
    check("full zoneC cand_rdy", 64'(cand_rdy), 64'd1);
    tick();
    drive(1, 26'h104, 8'b0000_0001, 3'd0, 0, 0); #1;
    check("full zoneE again cand_rdy", 64'(cand_rdy), 64'd0);
    check("full stalled pf_addr", 64'(pf_addr), 64'(addr_of(26'h100, 3'd0)));
    tick();
    // Flush while pf_vld=1 and pf_rdy=0.
    drive(1, 26'h102, 8'b0000_0100, 3'd0, 0, 1); #1;
    check("flush pf_vld before", 64'(pf_vld), 64'd1);
    check("flush cycle cand_rdy", 64'(cand_rdy), 64'd0);
    tick();
    drive(0, '0, '0, '0, 0, 0); #1;
    check("after flush pf_vld", 64'(pf_vld), 64'd0);
    check("after flush busy", 64'(busy), 64'd0);
    check("after flush cand_rdy", 64'(cand_rdy), 64'd1);
    tick();

    // Zero mask is accepted and dropped.
    drive(1, 26'h55, 8'h00, 3'd2, 1, 0); #1;
    check("zero mask cand_rdy", 64'(cand_rdy), 64'd1);
    tick();
    drive(0, '0, '0, '0, 1, 0); #1;
    check("zero mask c1 busy", 64'(busy), 64'd0);
    tick();
    #1;
    check("zero mask c2 busy", 64'(busy), 64'd0);
    check("zero mask c2 pf_vld", 64'(pf_vld), 64'd0);
    tick();

    // Handshake in the flush cycle still yields its update pulse.
    zb = 26'h77;
    drive(1, zb, 8'b0000_0001, 3'd0, 0, 0); #1;
    tick();
    drive(0, '0, '0, '0, 0, 0); #1;
    tick();
    drive(0, '0, '0, '0, 1, 1); #1;
    check("flush fire pf_vld", 64'(pf_vld), 64'd1);
    tick();
    drive(0, '0, '0, '0, 0, 0); #1;
    check("flush fire upd_vld", 64'(upd_vld), 64'd1);
    check("flush fire upd_zone", 64'(upd_zone), 64'(zb));
    check("flush fire upd_line", 64'(upd_line), 64'd0);
    check("flush fire pf_vld after", 64'(pf_vld), 64'd0);
    tick();

    // Reset mid-issue with a handshake pending.
    drive(1, 26'h3ABCDE, 8'b0100_0000, 3'd6, 0, 0); #1;
    tick();
    drive(0, '0, '0, '0, 0, 0); #1;
    tick();
    #1;
    check("rst mid pf_vld", 64'(pf_vld), 64'd1);
    check("rst mid pf_addr", 64'(pf_addr), 64'(addr_of(26'h3ABCDE, 3'd6)));
    pf_rdy = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst async pf_vld", 64'(pf_vld), 64'd0);
    check("rst async pf_addr", 64'(pf_addr), 64'd0);
    check("rst async upd_vld", 64'(upd_vld), 64'd0);
    check("rst async upd_zone", 64'(upd_zone), 64'd0);
    check("rst async upd_line", 64'(upd_line), 64'd0);
    check("rst async busy", 64'(busy), 64'd0);
    check("rst async cand_rdy", 64'(cand_rdy), 64'd1);
    tick();
    #1;
    check("rst held upd_vld", 64'(upd_vld), 64'd0);
    rst_n = 1'b1;
    drive(1, 26'h21, 8'b0000_1000, 3'd3, 1, 0); #1;
    check("post rst cand_rdy", 64'(cand_rdy), 64'd1);
    tick();
    drive(0, '0, '0, '0, 1, 0); #1;
    check("post rst c1 pf_vld", 64'(pf_vld), 64'd0);
    check("post rst c1 upd_vld", 64'(upd_vld), 64'd0);
    tick();
    #1;
    check("post rst c2 pf_vld", 64'(pf_vld), 64'd1);
    check("post rst c2 pf_addr", 64'(pf_addr), 64'(addr_of(26'h21, 3'd3)));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
